// File: rtl/bram_port_master_if.sv
// bram_port_master_if
//   Bundles the three signal groups of a BRAM port initiator:
//     req_*  client request channel (valid/ready)
//     rsp_*  read-response channel (valid/ready)
//     ram_*  block RAM port
//   modport master : the initiator's view (bram_port_master)
//   modport slave  : the surrounding client and RAM's view
interface bram_port_master_if #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 ram_en;
  logic                 ram_we;
  logic [AddrWidth-1:0] ram_addr;
  logic [DataWidth-1:0] ram_din;
  logic                 ram_regce;
  logic [DataWidth-1:0] ram_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_en, ram_we, ram_addr, ram_din, ram_regce
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_en, ram_we, ram_addr, ram_din, ram_regce
  );
endinterface

// File: rtl/bram_port_master.sv
// bram_port_master
//   Initiator for one port of a single-clock block RAM. Accepts read/write
//   requests, issues one RAM access per accepted request, tracks the fixed
//   RAM read latency and returns read data in order through a response FIFO.
//   Writes produce no response.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bram_port_master_if.master (request, response and RAM port signals)
// Configuration
//   BRAM_PORT_MASTER_OUTREG_EN defined: RAM output register in use, read
//   latency 2, ram_regce pulses the cycle after each read issue.
//   Undefined: read latency 1, ram_regce held 0.
module bram_port_master #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 8,
  parameter int RspDepth  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_master_if.master    bus
);

`ifdef BRAM_PORT_MASTER_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int PtrW = $clog2(RspDepth);
  localparam int CntW = PtrW + 1;

  logic                 run_q;
  logic [Lat-1:0]       trk_q;
  logic [Lat-1:0]       trk_next;
  logic [DataWidth-1:0] fifo_q [RspDepth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [CntW-1:0]      inflight;
  logic [CntW-1:0]      occ;
  logic                 ready;
  logic                 issue;
  logic                 rd_issue;
  logic                 push;
  logic                 pop;

  // Credit covers both buffered and in-flight reads, so a read is only issued
  // when its data is guaranteed a FIFO slot. Depends only on state, never on
  // req_valid. run_q keeps ready low until the first edge after reset.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < Lat; i++) begin
      inflight = inflight + CntW'(trk_q[i]);
    end
  end

  assign occ      = count_q + inflight;
  assign ready    = run_q & (occ < CntW'(RspDepth));
  assign issue    = bus.req_valid & ready;
  assign rd_issue = issue & ~bus.req_we;
  assign push     = trk_q[Lat-1];
  assign pop      = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    trk_next    = trk_q << 1;
    trk_next[0] = rd_issue;
  end

  assign bus.req_ready = ready;
  assign bus.ram_en    = issue;
  assign bus.ram_we    = issue & bus.req_we;
  // Address/data are zeroed when idle so the port is quiet while no access is issued.
  assign bus.ram_addr  = issue ? bus.req_addr  : '0;
  assign bus.ram_din   = issue ? bus.req_wdata : '0;
`ifdef BRAM_PORT_MASTER_OUTREG_EN
  assign bus.ram_regce = trk_q[0];
`else
  assign bus.ram_regce = 1'b0;
`endif

  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_rdata = fifo_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      trk_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RspDepth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      trk_q <= trk_next;
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.ram_dout;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_master.sv
module tb_bram_port_master;
`ifdef BRAM_PORT_MASTER_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  bram_port_master_if #(.AddrWidth(12), .DataWidth(8)) bus ();

  bram_port_master #(.AddrWidth(12), .DataWidth(8), .RspDepth(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Write-first block RAM model with optional output register.
  logic [7:0] ram_mem [4096];
  logic [7:0] ram_lat;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram_mem[bus.ram_addr] <= bus.ram_din;
        ram_lat               <= bus.ram_din;
      end else begin
        ram_lat <= ram_mem[bus.ram_addr];
      end
    end
  end
`ifdef BRAM_PORT_MASTER_OUTREG_EN
  logic [7:0] ram_reg;
  always @(posedge clk) if (bus.ram_regce) ram_reg <= ram_lat;
  assign bus.ram_dout = ram_reg;
`else
  assign bus.ram_dout = ram_lat;
`endif

  // Read-stream driver state: reads go to address rd_sent % 8.
  int         rd_sent;
  int         rd_total;
  logic [7:0] rsp_q [$];

  task automatic drive_read();
    bus.req_we    = 1'b0;
    bus.req_wdata = 8'h00;
    bus.req_valid = (rd_sent < rd_total);
    bus.req_addr  = 12'(rd_sent % 8);
  endtask

  // Runs up to n cycles, starting and ending at posedge+1; stops early once
  // stop_at responses have been collected (stop_at=0: never).
  task automatic run_cycles(input int n, input int stop_at);
    bit acc, pp;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      pp  = bus.rsp_valid && bus.rsp_ready;
      if (pp) rsp_q.push_back(bus.rsp_rdata);
      @(posedge clk); #1;
      if (acc) rd_sent++;
      drive_read();
      if (stop_at != 0 && rsp_q.size() >= stop_at) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1;
    bus.req_addr = 12'h005; bus.req_wdata = 8'h33; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.ram_en, bus.ram_we, bus.ram_regce} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.req_ready, bus.rsp_valid, bus.ram_en, bus.ram_we, bus.ram_regce});
    end
    n_checks++;
    if ({bus.ram_addr, bus.ram_din, bus.rsp_rdata} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {bus.ram_addr, bus.ram_din, bus.rsp_rdata});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", bus.req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release: got %b expected 1", bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'h010; bus.req_wdata = 8'hA5;
    @(negedge clk);
    n_checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 1'b1, 12'h010, 8'hA5}) begin
      n_fail++;
      $display("FAIL write_port: got %h expected %h",
               {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din}, {1'b1, 1'b1, 12'h010, 8'hA5});
    end
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_wdata = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 12'h010}) begin
      n_fail++;
      $display("FAIL read_port: got %h expected %h",
               {bus.ram_en, bus.ram_we, bus.ram_addr}, {1'b1, 1'b0, 12'h010});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.ram_regce} !== {1'b0, (Lat == 2)}) begin
      n_fail++;
      $display("FAIL after_accept valid/regce: got %b expected %b",
               {bus.rsp_valid, bus.ram_regce}, {1'b0, (Lat == 2)});
    end
    for (int e = 1; e <= Lat; e++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.ram_regce} !== {(e == Lat), 1'b0}) begin
        n_fail++;
        $display("FAIL latency edge %0d valid/regce: got %b expected %b",
                 e, {bus.rsp_valid, bus.ram_regce}, {(e == Lat), 1'b0});
      end
    end
    n_checks++;
    if (bus.rsp_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL read_data: got %h expected a5", bus.rsp_rdata);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got %b expected 0", bus.rsp_valid);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1;
      bus.req_addr = 12'(i); bus.req_wdata = 8'hC0 + 8'(i);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    rsp_q.delete(); rd_sent = 0; rd_total = 8;
    drive_read();
    run_cycles(12, 0);
    n_checks++;
    if (rd_sent !== 4) begin
      n_fail++; $display("FAIL accepted_when_stalled: got %0d expected 4", rd_sent);
    end
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_when_full: got %b expected 0", bus.req_ready);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 8'hC0}) begin
      n_fail++;
      $display("FAIL held_head: got %h expected %h", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 8'hC0});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    run_cycles(40, 8);
    run_cycles(3, 0);
    n_checks++;
    if (rsp_q.size() !== 8) begin
      n_fail++; $display("FAIL rsp_count: got %0d expected 8", rsp_q.size());
    end
    for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
      n_checks++;
      if (rsp_q[i] !== 8'hC0 + 8'(i)) begin
        n_fail++; $display("FAIL order[%0d]: got %h expected %h", i, rsp_q[i], 8'hC0 + 8'(i));
      end
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_sustained();
    rsp_q.delete(); rd_sent = 0; rd_total = 4;
    bus.rsp_ready = 1'b0;
    drive_read();
    run_cycles(8, 0);
    rd_total = 24;
    drive_read();
    bus.rsp_ready = 1'b1;
    run_cycles(20, 0);
    n_checks++;
    if (rsp_q.size() !== 20) begin
      n_fail++; $display("FAIL sustained_rate: got %0d rsps in 20 cycles expected 20", rsp_q.size());
    end
    run_cycles(30, 24);
    n_checks++;
    if (rsp_q.size() !== 24) begin
      n_fail++; $display("FAIL sustained_total: got %0d expected 24", rsp_q.size());
    end
    for (int k = 0; k < 24 && k < rsp_q.size(); k++) begin
      n_checks++;
      if (rsp_q[k] !== 8'hC0 + 8'(k % 8)) begin
        n_fail++; $display("FAIL sustained[%0d]: got %h expected %h", k, rsp_q[k], 8'hC0 + 8'(k % 8));
      end
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    int seen;
    rsp_q.delete(); rd_sent = 0; rd_total = 2;
    bus.rsp_ready = 1'b0;
    drive_read();
    run_cycles(2, 0);
    n_checks++;
    if (rd_sent !== 2) begin
      n_fail++; $display("FAIL inflight_accept: got %0d expected 2", rd_sent);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL in_reset: got %b expected 00", {bus.rsp_valid, bus.req_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL stale_rsp: got %0d valid cycles expected 0", seen);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b expected 1", bus.req_ready);
    end
    @(posedge clk); #1;
    rsp_q.delete(); rd_sent = 3; rd_total = 4;
    bus.rsp_ready = 1'b1;
    drive_read();
    run_cycles(10, 1);
    n_checks++;
    if (rsp_q.size() < 1 || rsp_q[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL read_after_reset: got %0d rsps first %h expected c3",
               rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 8'h00);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_write_first();
    bit got;
    int extra;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 12'h020; bus.req_wdata = 8'h11;
    @(posedge clk); #1;
    bus.req_wdata = 8'h77;
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_wdata = 8'h00;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if ({got, bus.rsp_rdata} !== {1'b1, 8'h77}) begin
      n_fail++; $display("FAIL write_then_read: got %h expected %h", {got, bus.rsp_rdata}, {1'b1, 8'h77});
    end
    bus.rsp_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL writes_no_rsp: got %0d extra rsps expected 0", extra);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rd_sent = 0; rd_total = 0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_sustained();
    test_reset_inflight();
    test_write_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
